// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its rotating
// priority selector. Index widths are sized for the largest supported NREQ.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Largest requester count supported; one-hot and index helpers are sized to it.
  localparam int ONEHOT_W = 8;
  localparam int IDX_W    = $clog2(ONEHOT_W);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [IDX_W-1:0] idx);
    return ONEHOT_W'(1) << idx;
  endfunction

  // First set bit of req, searching ptr, ptr+1, ... wrapping at nreq.
  function automatic pick_t rr_pick(input logic [ONEHOT_W-1:0] req,
                                    input logic [IDX_W-1:0]    ptr,
                                    input int                  nreq);
    pick_t p;
    int    j;
    p = '0;
    for (int k = 0; k < ONEHOT_W; k++) begin
      if (k < nreq) begin
        j = int'(ptr) + k;
        if (j >= nreq) j = j - nreq;
        if (!p.valid && req[j[IDX_W-1:0]]) begin
          p.valid = 1'b1;
          p.idx   = j[IDX_W-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// Combinational rotating-priority encoder: returns the first active request
// at or after ptr (wrapping). Shared by the write arbiter and read-side users.
import fifo_arb_pkg::*;

module rr_select #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  pick_t pick;

  // NOTE: every output of a combinational block gets a value on every path;
  // the unconditional call below is what keeps this free of latches.
  always_comb begin
    pick  = rr_pick(ONEHOT_W'(req), ptr, NREQ);
    idx   = pick.idx;
    valid = pick.valid;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters,
// granting whole bursts and stalling beats while the FIFO is full.
import fifo_arb_pkg::*;

module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16,
  parameter int CW        = 8
) (
  input  logic             rst,
  input  logic             clkw,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [NREQ-1:0]  last,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  ack,
  input  logic             fifo_full,
  output logic             fifo_wreq,
  output logic [DW-1:0]    fifo_wd,
  output logic             busy
);

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;
  logic [CW-1:0]    beat_cnt;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;

  logic [ONEHOT_W-1:0] req_ext;
  logic [ONEHOT_W-1:0] last_ext;
  logic             owner_req;
  logic             owner_last;
  logic             beat;
  logic             at_max;
  logic             exit_now;
  logic [IDX_W-1:0] next_ptr;

  rr_select #(
    .NREQ (NREQ)
  ) u_rr_select (
    .req   (req),
    .ptr   (ptr),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  always_comb begin
    req_ext    = ONEHOT_W'(req);
    last_ext   = ONEHOT_W'(last);
    owner_req  = req_ext[owner];
    owner_last = last_ext[owner];
    beat       = (state == BURST) && owner_req && !fifo_full;
    at_max     = (beat_cnt == CW'(MAX_BURST - 1));
    // Dropping the request ends the burst without writing that cycle.
    exit_now   = !owner_req || (beat && (owner_last || at_max));
    next_ptr   = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
  end

  always_comb begin
    fifo_wreq = beat;
    ack       = beat ? NREQ'(onehot(owner)) : '0;
    fifo_wd   = (state == BURST) ? wdata[int'(owner)*DW +: DW] : '0;
    busy      = (state == BURST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clkw or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            state    <= BURST;
            owner    <= sel_idx;
            gnt      <= NREQ'(onehot(sel_idx));
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (exit_now) begin
            state    <= IDLE;
            gnt      <= '0;
            beat_cnt <= '0;
            ptr      <= next_ptr;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single FIFO write port (WREQ/WD, full flag f) among NREQ requesters in the clkw domain.
- Grants whole bursts: the owner keeps the port until it signals last, hits MAX_BURST beats, or drops its request.
- Stalls writes while the FIFO reports full.
- Sits between local write masters (e.g. APB-side register writers) and the FIFO write side.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width; matches FIFO WD width
- MAX_BURST, 16, max beats per grant (1..255)
- CW, 8, beat counter width; must satisfy 2^CW > MAX_BURST

Ports:
- rst  in  1  async reset, active-low
- clkw  in  1  write-side clock
- req  in  NREQ  per-requester write request (level)
- wdata  in  NREQ*DW  per-requester data, requester i at bits [i*DW +: DW]
- last  in  NREQ  marks the requester's final beat of its burst
- gnt  out  NREQ  one-hot registered grant (owner)
- ack  out  NREQ  one-hot, beat accepted this cycle (combinational)
- fifo_full  in  1  FIFO full flag f
- fifo_wreq  out  1  drives FIFO WREQ
- fifo_wd  out  DW  drives FIFO WD
- busy  out  1  high while state is BURST

Behaviour:
- Reset (rst low, async, immediate):
  - state=IDLE, gnt=0, ptr=0, beat_cnt=0.
  - Hence fifo_wreq=0, ack=0, busy=0, fifo_wd=0.
  - Reset mid-burst abandons the burst silently; no beat is written after rst falls.
- State machine has two states, IDLE and BURST.
- IDLE:
  - If req!=0, choose the first i with req[i]=1, searching ptr, ptr+1, ... mod NREQ.
  - At the next clkw edge: gnt=onehot(i), owner=i, beat_cnt=0, state=BURST.
  - Grant latency is 1 cycle after req is seen. No writes occur in IDLE.
- BURST, write condition:
  - beat = req[owner] & ~fifo_full.
  - fifo_wreq = beat; ack[owner] = beat; fifo_wd = wdata[owner].
  - fifo_wd = 0 when not in BURST.
  - Each beat increments beat_cnt.
- BURST, exit (any of the following, evaluated at the clkw edge):
  - (a) beat & last[owner]
  - (b) beat & (beat_cnt == MAX_BURST-1)
  - (c) ~req[owner], i.e. requester abandoned; no beat is written that cycle.
- On exit:
  - state=IDLE, gnt=0, ptr=(owner+1) mod NREQ.
  - One idle cycle always separates bursts. This is intended, for a deterministic turnaround.
- Full stall: while fifo_full=1 in BURST, fifo_wreq=0 and ack=0. The grant is held indefinitely and beat_cnt is frozen.
- Simultaneous last and full: no beat, so no exit. The requester must hold data and last until ack.
- Requesters may change req freely in IDLE. Non-owners are ignored during BURST.
- Wrap-around: ptr wraps from NREQ-1 to 0. beat_cnt never exceeds MAX_BURST-1 because of rule (b).
- Fairness: a requester continuously asserting req is granted within NREQ-1 other bursts.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state encoding (IDLE=0, BURST=1)
  - a localparam for the onehot helper width
  - function rr_pick(req, ptr)
- One sub-module, rr_select: combinational rotating priority encoder (req, ptr -> idx, valid), reusable for a read-side arbiter.
- The rest is flat.

Test Plan:
- Reset: rst=0 mid-burst with req=4'b0001 and beats in flight -> gnt=0, fifo_wreq=0 on the same cycle, no further writes. After rst=1 with req=4'b0010, gnt=4'b0010 one cycle later.
- Round robin: req=4'b1111 held, each requester bursts 2 beats (last on the 2nd) -> grant order 0,1,2,3,0. Exactly 2 fifo_wreq pulses per grant, 1 idle cycle between grants.
- MAX_BURST=16: req0 held with last=0 -> exactly 16 beats written (data 0x00..0x0F), then gnt drops and ptr=1.
- Full stall: owner 2 mid-burst, fifo_full=1 for 5 cycles -> fifo_wreq=0 and ack=0 for those 5 cycles, gnt stays 4'b0100. Writes resume on the first cycle full=0, with beat count continuous.
- Abandon: owner 1 drops req after 3 beats -> no 4th write, state IDLE next cycle. Next grant goes to the lowest pending index >=2 (wrapping).
- Last while full: last[0]=1 and fifo_full=1 for 2 cycles -> burst stays open. Exit occurs only on the cycle the beat is accepted with fifo_wd equal to the held data.
